// File: rtl/ttl_161_raster_seq.sv
// rtl/ttl_161_raster_seq.sv - raster timing sequencer built on a cascaded 161-style H/V counter chain
//
// Purpose: advances H once per qualified pixel tick (rising edge of Cen, ignored while Hold is
// high). When H is at all ones it reloads H_START and V advances. Blank and sync windows are
// decoded from the next counts and registered on the same edge, so each flag matches its count.
//
// Ports:
//   Clk        in   system clock, all state on posedge
//   Clear_bar  in   asynchronous active-low reset
//   Cen        in   pixel clock enable, only its 0->1 transition counts
//   Hold       in   freeze raster, ticks seen while high are dropped
//   HCnt/VCnt  out  horizontal / vertical counts
//   HLoad_bar  out  low while HCnt is all ones
//   VLoad_bar  out  low while HCnt and VCnt are both all ones
//   VTick      out  one-Clk pulse when V advances or reloads
//   FrameStart out  one-Clk pulse when both counters reload together
//   HBlank/HSync/VBlank/VSync out  registered window flags, sync active high
module ttl_161_raster_seq #(
    parameter int HW      = 9,
    parameter int VW      = 9,
    parameter int H_START = 128,
    parameter int V_START = 248,
    parameter int HBL_END = 136,
    parameter int HBL_BEG = 392,
    parameter int HS_BEG  = 416,
    parameter int HS_END  = 448,
    parameter int VBL_END = 256,
    parameter int VBL_BEG = 496,
    parameter int VS_BEG  = 500,
    parameter int VS_END  = 504
) (
    input  logic          Clk,
    input  logic          Clear_bar,
    input  logic          Cen,
    input  logic          Hold,
    output logic [HW-1:0] HCnt,
    output logic [VW-1:0] VCnt,
    output logic          HLoad_bar,
    output logic          VLoad_bar,
    output logic          VTick,
    output logic          FrameStart,
    output logic          HBlank,
    output logic          HSync,
    output logic          VBlank,
    output logic          VSync
);

    localparam int H_LIM = 1 << HW;
    localparam int V_LIM = 1 << VW;

    localparam logic [HW-1:0] H_ALL   = {HW{1'b1}};
    localparam logic [VW-1:0] V_ALL   = {VW{1'b1}};
    localparam logic [HW-1:0] H_START_V = HW'(H_START);
    localparam logic [VW-1:0] V_START_V = VW'(V_START);

    // Window bounds may equal 2^W, so compares are done one bit wider than the counters.
    localparam logic [HW:0] HBL_END_V = (HW+1)'(HBL_END);
    localparam logic [HW:0] HBL_BEG_V = (HW+1)'(HBL_BEG);
    localparam logic [HW:0] HS_BEG_V  = (HW+1)'(HS_BEG);
    localparam logic [HW:0] HS_END_V  = (HW+1)'(HS_END);
    localparam logic [VW:0] VBL_END_V = (VW+1)'(VBL_END);
    localparam logic [VW:0] VBL_BEG_V = (VW+1)'(VBL_BEG);
    localparam logic [VW:0] VS_BEG_V  = (VW+1)'(VS_BEG);
    localparam logic [VW:0] VS_END_V  = (VW+1)'(VS_END);

    generate
        if (!(H_START >= 0 && H_START < H_LIM - 1 && V_START >= 0 && V_START < V_LIM - 1)) begin : g_bad_start
            $error("ttl_161_raster_seq: start values must be below the all-ones count");
        end
        if (!(HBL_END >= H_START && HBL_END <= H_LIM && HBL_BEG >= H_START && HBL_BEG <= H_LIM &&
              HS_BEG  >= H_START && HS_BEG  <= H_LIM && HS_END  >= H_START && HS_END  <= H_LIM &&
              VBL_END >= V_START && VBL_END <= V_LIM && VBL_BEG >= V_START && VBL_BEG <= V_LIM &&
              VS_BEG  >= V_START && VS_BEG  <= V_LIM && VS_END  >= V_START && VS_END  <= V_LIM)) begin : g_bad_window
            $error("ttl_161_raster_seq: window bound outside counter range");
        end
    endgenerate

    function automatic logic h_blank_of(input logic [HW-1:0] h);
        return ({1'b0, h} < HBL_END_V) || ({1'b0, h} >= HBL_BEG_V);
    endfunction

    function automatic logic h_sync_of(input logic [HW-1:0] h);
        return ({1'b0, h} >= HS_BEG_V) && ({1'b0, h} < HS_END_V);
    endfunction

    function automatic logic v_blank_of(input logic [VW-1:0] v);
        return ({1'b0, v} < VBL_END_V) || ({1'b0, v} >= VBL_BEG_V);
    endfunction

    function automatic logic v_sync_of(input logic [VW-1:0] v);
        return ({1'b0, v} >= VS_BEG_V) && ({1'b0, v} < VS_END_V);
    endfunction

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          last_cen_q, last_cen_d;
    logic          vtick_q, vtick_d;
    logic          frame_q, frame_d;
    logic          hblank_q, hblank_d;
    logic          hsync_q, hsync_d;
    logic          vblank_q, vblank_d;
    logic          vsync_q, vsync_d;

    logic tick;
    logic h_wrap;
    logic v_wrap;

    always_comb begin
        // last_cen tracks Cen even during Hold so a level held across Hold never counts as a rise.
        tick       = Cen & ~last_cen_q & ~Hold;
        h_wrap     = (hcnt_q == H_ALL);
        v_wrap     = (vcnt_q == V_ALL);
        last_cen_d = Cen;
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        vtick_d    = 1'b0;
        frame_d    = 1'b0;
        if (tick) begin
            hcnt_d = h_wrap ? H_START_V : hcnt_q + HW'(1);
            if (h_wrap) begin
                vcnt_d  = v_wrap ? V_START_V : vcnt_q + VW'(1);
                vtick_d = 1'b1;
                frame_d = v_wrap;
            end
        end
        // Decode from the next counts so the registered flags line up with the registered counts.
        hblank_d = h_blank_of(hcnt_d);
        hsync_d  = h_sync_of(hcnt_d);
        vblank_d = v_blank_of(vcnt_d);
        vsync_d  = v_sync_of(vcnt_d);
    end

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            hcnt_q     <= H_START_V;
            vcnt_q     <= V_START_V;
            last_cen_q <= 1'b1;
            vtick_q    <= 1'b0;
            frame_q    <= 1'b0;
            hblank_q   <= h_blank_of(H_START_V);
            hsync_q    <= h_sync_of(H_START_V);
            vblank_q   <= v_blank_of(V_START_V);
            vsync_q    <= v_sync_of(V_START_V);
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            last_cen_q <= last_cen_d;
            vtick_q    <= vtick_d;
            frame_q    <= frame_d;
            hblank_q   <= hblank_d;
            hsync_q    <= hsync_d;
            vblank_q   <= vblank_d;
            vsync_q    <= vsync_d;
        end
    end

    assign HCnt       = hcnt_q;
    assign VCnt       = vcnt_q;
    assign HLoad_bar  = ~(hcnt_q == H_ALL);
    assign VLoad_bar  = ~((hcnt_q == H_ALL) && (vcnt_q == V_ALL));
    assign VTick      = vtick_q;
    assign FrameStart = frame_q;
    assign HBlank     = hblank_q;
    assign HSync      = hsync_q;
    assign VBlank     = vblank_q;
    assign VSync      = vsync_q;

endmodule

// File: tb/tb_ttl_161_raster_seq.sv
// tb/tb_ttl_161_raster_seq.sv - bench for ttl_161_raster_seq, default and reduced-size instances
module tb_ttl_161_raster_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cen = 1'b1;
    logic hold = 1'b0;
    bit   chk_en = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance A: default raster.
    logic [8:0] hc_a, vc_a;
    logic hlb_a, vlb_a, vt_a, fs_a, hb_a, hs_a, vb_a, vs_a;

    ttl_161_raster_seq dut_a (
        .Clk(clk), .Clear_bar(rst_n), .Cen(cen), .Hold(hold),
        .HCnt(hc_a), .VCnt(vc_a), .HLoad_bar(hlb_a), .VLoad_bar(vlb_a),
        .VTick(vt_a), .FrameStart(fs_a), .HBlank(hb_a), .HSync(hs_a),
        .VBlank(vb_a), .VSync(vs_a)
    );

    // Instance B: tiny raster (6 ticks/line, 5 lines/frame) so whole frames fit in the run.
    logic [3:0] hc_b;
    logic [2:0] vc_b;
    logic hlb_b, vlb_b, vt_b, fs_b, hb_b, hs_b, vb_b, vs_b;

    ttl_161_raster_seq #(
        .HW(4), .VW(3), .H_START(10), .V_START(3),
        .HBL_END(11), .HBL_BEG(14), .HS_BEG(12), .HS_END(14),
        .VBL_END(4), .VBL_BEG(7), .VS_BEG(5), .VS_END(6)
    ) dut_b (
        .Clk(clk), .Clear_bar(rst_n), .Cen(cen), .Hold(hold),
        .HCnt(hc_b), .VCnt(vc_b), .HLoad_bar(hlb_b), .VLoad_bar(vlb_b),
        .VTick(vt_b), .FrameStart(fs_b), .HBlank(hb_b), .HSync(hs_b),
        .VBlank(vb_b), .VSync(vs_b)
    );

    // Model: count qualified ticks since reset; positions follow from modular arithmetic.
    int  t_cnt;
    bit  ticked;
    bit  prev_cen;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_cnt    <= 0;
            ticked   <= 1'b0;
            prev_cen <= 1'b1;
        end else begin
            prev_cen <= cen;
            ticked   <= cen && !prev_cen && !hold;
            if (cen && !prev_cen && !hold) t_cnt <= t_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string p, input int hw, input int vw, input int hst, input int vst,
                            input int hbe, input int hbb, input int hsb, input int hse,
                            input int vbe, input int vbb, input int vsb, input int vse,
                            input logic [31:0] hc, input logic [31:0] vc,
                            input logic hlb, input logic vlb, input logic vt, input logic fs,
                            input logic hb, input logic hs, input logic vb, input logic vs);
        int line, lines, h, v;
        line  = (1 << hw) - hst;
        lines = (1 << vw) - vst;
        h = hst + (t_cnt % line);
        v = vst + ((t_cnt / line) % lines);
        chk({p, "_hcnt"}, hc, h);
        chk({p, "_vcnt"}, vc, v);
        chk({p, "_hload_bar"}, 32'(hlb), 32'(h != (1 << hw) - 1));
        chk({p, "_vload_bar"}, 32'(vlb), 32'(!(h == (1 << hw) - 1 && v == (1 << vw) - 1)));
        chk({p, "_vtick"}, 32'(vt), 32'(ticked && (t_cnt % line) == 0));
        chk({p, "_framestart"}, 32'(fs), 32'(ticked && (t_cnt % (line * lines)) == 0));
        chk({p, "_hblank"}, 32'(hb), 32'(h < hbe || h >= hbb));
        chk({p, "_hsync"}, 32'(hs), 32'(h >= hsb && h < hse));
        chk({p, "_vblank"}, 32'(vb), 32'(v < vbe || v >= vbb));
        chk({p, "_vsync"}, 32'(vs), 32'(v >= vsb && v < vse));
    endtask

    int fs_a_cnt = 0;
    int fs_b_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst("a", 9, 9, 128, 248, 136, 392, 416, 448, 256, 496, 500, 504,
                     32'(hc_a), 32'(vc_a), hlb_a, vlb_a, vt_a, fs_a, hb_a, hs_a, vb_a, vs_a);
            cmp_inst("b", 4, 3, 10, 3, 11, 14, 12, 14, 4, 7, 5, 6,
                     32'(hc_b), 32'(vc_b), hlb_b, vlb_b, vt_b, fs_b, hb_b, hs_b, vb_b, vs_b);
            if (fs_a) fs_a_cnt++;
            if (fs_b) fs_b_cnt++;
        end
    end

    task automatic tick_once();
        @(negedge clk) cen = 1'b1;
        @(negedge clk) cen = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_once();
    endtask

    int hs_high;
    int vt_at;

    initial begin
        // 1: reset with Cen high, release with Cen still high: no tick.
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t1_hcnt", 32'(hc_a), 128);
        chk("t1_vcnt", 32'(vc_a), 248);
        chk("t1_hblank", 32'(hb_a), 1);
        chk("t1_vblank", 32'(vb_a), 1);
        chk("t1_hsync", 32'(hs_a), 0);
        chk("t1_vtick", 32'(vt_a), 0);
        cen = 1'b0;

        // 2: walk to the end of the first line.
        ticks(383);
        chk("t2_h511", 32'(hc_a), 511);
        chk("t2_hload_bar", 32'(hlb_a), 0);
        chk("t2_vload_bar", 32'(vlb_a), 1);
        tick_once();
        chk("t2_hwrap", 32'(hc_a), 128);
        chk("t2_vadv", 32'(vc_a), 249);
        chk("t2_vtick", 32'(vt_a), 1);
        chk("t2_b_frames", 32'(fs_b_cnt), 12);

        // 3: one full line, blank/sync edges and line length.
        hs_high = 0;
        vt_at = -1;
        for (int i = 1; i <= 384; i++) begin
            tick_once();
            if (hs_a) hs_high++;
            if (vt_a && vt_at < 0) vt_at = i;
            if (i == 7)   chk("t3_hblank_135", 32'(hb_a), 1);
            if (i == 8)   chk("t3_hblank_136", 32'(hb_a), 0);
            if (i == 263) chk("t3_hblank_391", 32'(hb_a), 0);
            if (i == 264) chk("t3_hblank_392", 32'(hb_a), 1);
        end
        chk("t3_hsync_ticks", 32'(hs_high), 32);
        chk("t3_line_len", 32'(vt_at), 384);
        chk("t3_vcnt", 32'(vc_a), 250);

        // 4: vertical blank end at V=256.
        ticks(6 * 384 - 1);
        chk("t4_v255", 32'(vc_a), 255);
        chk("t4_vblank_255", 32'(vb_a), 1);
        tick_once();
        chk("t4_v256", 32'(vc_a), 256);
        chk("t4_vblank_256", 32'(vb_a), 0);

        // 5: hold at H=300 drops ticks, no catch-up afterwards.
        ticks(172);
        chk("t5_h300", 32'(hc_a), 300);
        hold = 1'b1;
        ticks(20);
        chk("t5_held", 32'(hc_a), 300);
        hold = 1'b0;
        tick_once();
        chk("t5_resume", 32'(hc_a), 301);

        // 6: reset mid-line at H=450, V=300, between clock edges.
        ticks(211 + 43 * 384 + 322);
        chk("t6_h450", 32'(hc_a), 450);
        chk("t6_v300", 32'(vc_a), 300);
        chk("t6_a_frames", 32'(fs_a_cnt), 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_hcnt", 32'(hc_a), 128);
        chk("t6_vcnt", 32'(vc_a), 248);
        chk("t6_hblank", 32'(hb_a), 1);
        chk("t6_hsync", 32'(hs_a), 0);
        chk("t6_vblank", 32'(vb_a), 1);
        chk("t6_vsync", 32'(vs_a), 0);
        chk("t6_vtick", 32'(vt_a), 0);
        chk("t6_framestart", 32'(fs_a), 0);
        chk("t6_b_hcnt", 32'(hc_b), 10);
        chk("t6_b_vcnt", 32'(vc_b), 3);
        repeat (2) @(negedge clk);
        chk("t6_vtick_held", 32'(vt_a), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tick_once();
        chk("t6_after", 32'(hc_a), 129);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
